mips_core: RTL and testbench

MIPS_CORE -- requirements
Module: mips_core

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/mips_core_if.sv | 17 +
 rtl/mips_regfile.sv | 29 ++
 rtl/mips_storage.sv | 90 +++++++++
 rtl/mips_core.sv | 144 ++++++++++++++
 tb/tb_mips_core.sv | 331 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the single-cycle MIPS subset core.
// Holds the opcode and funct encodings, the ALU operation enum, the decoded
// control bundle and a 16-to-32-bit sign-extension helper.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef struct packed {
        logic       reg_we;   // write back to register file
        logic [4:0] wa;       // write-back register index
        logic       use_imm;  // ALU B operand is the sign-extended immediate
        logic       wb_mem;   // write-back data comes from data memory
        logic       mem_we;   // store to data memory
        logic       branch;   // beq
        logic       jump;     // j
        alu_op_t    alu_op;
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_core_if.sv
// mips_core_if -- register-file access bus between the core datapath and
// mips_regfile.
//   ra1/ra2 : read addresses (rs, rt)      rd1/rd2 : asynchronous read data
//   we/wa/wd: write enable, address, data (committed on the rising clock edge)
// master: datapath side, slave: register-file side.
interface mips_core_if;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;

    modport master (output ra1, ra2, we, wa, wd, input rd1, rd2);
    modport slave  (input ra1, ra2, we, wa, wd, output rd1, rd2);
endinterface

// File: rtl/mips_regfile.sv
// mips_regfile -- 32 x 32-bit register file.
//   clk : rising-edge clock          rst : synchronous active-high clear
//   bus : mips_core_if.slave -- two asynchronous read ports, one write port
// Register 0 reads as zero and ignores writes. A read of the register being
// written in the same cycle returns the old contents.
module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    mips_core_if.slave  bus
);

    logic [31:0] inReg [0:31] = '{default: 32'h0};

    always_comb begin
        bus.rd1 = (bus.ra1 == 5'd0) ? '0 : inReg[bus.ra1];
        bus.rd2 = (bus.ra2 == 5'd0) ? '0 : inReg[bus.ra2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                inReg[i[4:0]] <= '0;
            end
        end else if (bus.we && (bus.wa != 5'd0)) begin
            inReg[bus.wa] <= bus.wd;
        end
    end

endmodule

// File: rtl/mips_storage.sv
// State elements of the core with fixed instance-visible storage names.
//   mips_pc   : program counter register; clk, rst, next (D), out (Q).
//   mips_imem : byte-wide instruction ROM `mem`, little-endian asynchronous
//               word read; addr -> instr.
//   mips_dmem : byte-wide data RAM `mem`; asynchronous little-endian word
//               read (rdata) and rising-edge word write (we, wdata). The
//               address is word-aligned by dropping its two low bits.
// All byte addresses wrap modulo the memory size.

module mips_pc (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next,
    output logic [31:0] out
);

    logic [31:0] q = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= next;
        end
    end

    assign out = q;

endmodule

module mips_imem #(
    parameter int BYTES = 256
) (
    input  logic [31:0] addr,
    output logic [31:0] instr
);

    localparam int AW = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [7:0]  mem [0:BYTES-1] = '{default: 8'h00};
    logic [31:0] base;

    // Reduce first so pc+k cannot overflow before the modulo.
    function automatic logic [AW-1:0] idx(input logic [31:0] b, input logic [1:0] k);
        return AW'((b + {30'd0, k}) % 32'(BYTES));
    endfunction

    always_comb begin
        base  = addr % 32'(BYTES);
        instr = {mem[idx(base, 2'd3)], mem[idx(base, 2'd2)],
                 mem[idx(base, 2'd1)], mem[idx(base, 2'd0)]};
    end

endmodule

module mips_dmem #(
    parameter int BYTES = 256
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int AW = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [7:0]  mem [0:BYTES-1] = '{default: 8'h00};
    logic [31:0] base;

    function automatic logic [AW-1:0] idx(input logic [31:0] b, input logic [1:0] k);
        return AW'((b + {30'd0, k}) % 32'(BYTES));
    endfunction

    always_comb begin
        base  = (addr & 32'hFFFF_FFFC) % 32'(BYTES);
        rdata = {mem[idx(base, 2'd3)], mem[idx(base, 2'd2)],
                 mem[idx(base, 2'd1)], mem[idx(base, 2'd0)]};
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx(base, 2'd0)] <= wdata[7:0];
            mem[idx(base, 2'd1)] <= wdata[15:8];
            mem[idx(base, 2'd2)] <= wdata[23:16];
            mem[idx(base, 2'd3)] <= wdata[31:24];
        end
    end

endmodule

// File: rtl/mips_core.sv
// mips_core -- single-cycle 32-bit MIPS subset (add, sub, and, or, slt,
// addi, lw, sw, beq, j). One instruction is fetched, executed and retired
// per rising clock edge.
//   clk : rising-edge clock
//   rst : synchronous active-high reset; clears pc and the register file,
//         leaves both memories untouched
// State is reached through the instances pc, im, rg and dm.
// Unsupported opcodes/functs retire as a NOP (pc+4 only).
module mips_core
    import mips_pkg::*;
#(
    parameter int IMEM_BYTES = 256,
    parameter int DMEM_BYTES = 256
) (
    input  logic clk,
    input  logic rst
);

    logic [31:0] pc_out;
    logic [31:0] pc_next;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] imm_sx;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [31:0] mem_rdata;
    logic        mem_we;
    ctrl_t       ctrl;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;

    mips_core_if rbus ();

    mips_pc pc (
        .clk  (clk),
        .rst  (rst),
        .next (pc_next),
        .out  (pc_out)
    );

    mips_imem #(.BYTES(IMEM_BYTES)) im (
        .addr  (pc_out),
        .instr (instr)
    );

    mips_regfile rg (
        .clk (clk),
        .rst (rst),
        .bus (rbus)
    );

    mips_dmem #(.BYTES(DMEM_BYTES)) dm (
        .clk   (clk),
        .we    (mem_we),
        .addr  (alu_y),
        .wdata (rbus.rd2),
        .rdata (mem_rdata)
    );

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign imm_sx = sext16(instr[15:0]);

    // Decode
    always_comb begin
        ctrl        = '0;
        ctrl.wa     = rd;
        ctrl.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_we = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    default: ctrl.reg_we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                ctrl.reg_we  = 1'b1;
                ctrl.wa      = rt;
                ctrl.use_imm = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_we  = 1'b1;
                ctrl.wa      = rt;
                ctrl.use_imm = 1'b1;
                ctrl.wb_mem  = 1'b1;
            end
            OP_SW: begin
                ctrl.use_imm = 1'b1;
                ctrl.mem_we  = 1'b1;
            end
            OP_BEQ:  ctrl.branch = 1'b1;
            OP_J:    ctrl.jump   = 1'b1;
            default: ;
        endcase
    end

    // ALU
    always_comb begin
        alu_b = ctrl.use_imm ? imm_sx : rbus.rd2;
        case (ctrl.alu_op)
            ALU_ADD: alu_y = rbus.rd1 + alu_b;
            ALU_SUB: alu_y = rbus.rd1 - alu_b;
            ALU_AND: alu_y = rbus.rd1 & alu_b;
            ALU_OR:  alu_y = rbus.rd1 | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(rbus.rd1) < $signed(alu_b)};
            default: alu_y = rbus.rd1 + alu_b;
        endcase
    end

    // Next PC
    assign pc4 = pc_out + 32'd4;

    always_comb begin
        pc_next = pc4;
        if (ctrl.jump) begin
            pc_next = {pc4[31:28], instr[25:0], 2'b00};
        end else if (ctrl.branch && (rbus.rd1 == rbus.rd2)) begin
            pc_next = pc4 + (imm_sx << 2);
        end
    end

    // Register-file port; the regfile's own reset overrides the write.
    assign rbus.ra1 = rs;
    assign rbus.ra2 = rt;
    assign rbus.we  = ctrl.reg_we;
    assign rbus.wa  = ctrl.wa;
    assign rbus.wd  = ctrl.wb_mem ? mem_rdata : alu_y;

    // A store in flight during reset must not retire.
    assign mem_we = ctrl.mem_we & ~rst;

endmodule

// File: tb/tb_mips_core.sv
// tb_mips_core -- directed self-checking bench for mips_core. Programs are
// preloaded into dut.im.mem, results read from dut.pc.out, dut.rg.inReg and
// dut.dm.mem. A mips_core_if instance mirrors the register write port.
module tb_mips_core;

    localparam int IMEM_BYTES = 256;
    localparam int DMEM_BYTES = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] snap [0:DMEM_BYTES-1];

    mips_core #(.IMEM_BYTES(IMEM_BYTES), .DMEM_BYTES(DMEM_BYTES)) dut (
        .clk (clk),
        .rst (rst)
    );

    mips_core_if mon ();
    assign mon.ra1 = dut.rbus.ra1;
    assign mon.ra2 = dut.rbus.ra2;
    assign mon.rd1 = dut.rbus.rd1;
    assign mon.rd2 = dut.rbus.rd2;
    assign mon.we  = dut.rbus.we;
    assign mon.wa  = dut.rbus.wa;
    assign mon.wd  = dut.rbus.wd;

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic put(input int a, input logic [31:0] w);
        dut.im.mem[a]     = w[7:0];
        dut.im.mem[a + 1] = w[15:8];
        dut.im.mem[a + 2] = w[23:16];
        dut.im.mem[a + 3] = w[31:24];
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset while the program is swapped so nothing stale retires.
    task automatic begin_prog();
        rst = 1'b1;
        for (int i = 0; i < IMEM_BYTES; i++) dut.im.mem[i] = 8'h00;
    endtask

    task automatic end_prog();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_no_reset();
        put(0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        #1;
        checks++;
        if (dut.pc.out !== 32'd0) begin
            errors++; $display("FAIL init_pc: got %h expected %h", dut.pc.out, 32'd0);
        end
        checks++;
        if (mon.we !== 1'b1 || mon.wa !== 5'd1 || mon.wd !== 32'd5) begin
            errors++; $display("FAIL wport_addi: got we=%b wa=%0d wd=%h expected we=1 wa=1 wd=5",
                               mon.we, mon.wa, mon.wd);
        end
        step(1);
        checks++;
        if (dut.rg.inReg[1] !== 32'd5) begin
            errors++; $display("FAIL norst_r1: got %h expected %h", dut.rg.inReg[1], 32'd5);
        end
        checks++;
        if (dut.pc.out !== 32'd4) begin
            errors++; $display("FAIL norst_pc: got %h expected %h", dut.pc.out, 32'd4);
        end
    endtask

    task automatic test_reset();
        begin_prog();
        end_prog();
        checks++;
        if (dut.pc.out !== 32'd0) begin
            errors++; $display("FAIL reset_pc: got %h expected %h", dut.pc.out, 32'd0);
        end
        checks++;
        if (dut.rg.inReg[1] !== 32'd0) begin
            errors++; $display("FAIL reset_r1: got %h expected %h", dut.rg.inReg[1], 32'd0);
        end
    endtask

    task automatic test_arith();
        begin_prog();
        put(0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(4, enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        put(8, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        end_prog();
        step(3);
        checks++;
        if (dut.rg.inReg[3] !== 32'd12) begin
            errors++; $display("FAIL add_r3: got %h expected %h", dut.rg.inReg[3], 32'd12);
        end
        checks++;
        if (dut.pc.out !== 32'd12) begin
            errors++; $display("FAIL add_pc: got %h expected %h", dut.pc.out, 32'd12);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] exp_v [0:7];
        exp_v = '{32'hFFFF_FFFE, 32'd5, 32'd7, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd4, 32'd1};
        begin_prog();
        put(0,  enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(4,  enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        put(8,  enc_r(5'd1, 5'd2, 5'd3, 6'h22));
        put(12, enc_r(5'd1, 5'd2, 5'd4, 6'h24));
        put(16, enc_r(5'd1, 5'd2, 5'd5, 6'h25));
        put(20, enc_r(5'd1, 5'd2, 5'd6, 6'h2A));
        put(24, enc_r(5'd2, 5'd1, 5'd7, 6'h2A));
        put(28, enc_i(6'h08, 5'd0, 5'd8, 16'hFFFF));
        put(32, enc_r(5'd8, 5'd1, 5'd9, 6'h20));
        put(36, enc_r(5'd8, 5'd1, 5'd10, 6'h2A));
        end_prog();
        step(10);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.rg.inReg[i + 3] !== exp_v[i]) begin
                errors++; $display("FAIL alu_r%0d: got %h expected %h", i + 3,
                                   dut.rg.inReg[i + 3], exp_v[i]);
            end
        end
    endtask

    task automatic test_mem();
        logic [7:0] exp_b [0:7];
        exp_b = '{8'h0C, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00};
        begin_prog();
        put(0,  enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(4,  enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        put(8,  enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        put(12, enc_i(6'h2B, 5'd0, 5'd3, 16'd4));
        put(16, enc_i(6'h23, 5'd0, 5'd4, 16'd4));
        put(20, enc_i(6'h23, 5'd0, 5'd5, 16'd6));
        put(24, enc_i(6'h08, 5'd0, 5'd9, 16'h1234));
        put(28, enc_i(6'h2B, 5'd0, 5'd9, 16'd8));
        end_prog();
        step(8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.dm.mem[i + 4] !== exp_b[i]) begin
                errors++; $display("FAIL dmem[%0d]: got %h expected %h", i + 4,
                                   dut.dm.mem[i + 4], exp_b[i]);
            end
        end
        checks++;
        if (dut.rg.inReg[4] !== 32'd12) begin
            errors++; $display("FAIL lw_r4: got %h expected %h", dut.rg.inReg[4], 32'd12);
        end
        checks++;
        if (dut.rg.inReg[5] !== 32'd12) begin
            errors++; $display("FAIL lw_unaligned_r5: got %h expected %h", dut.rg.inReg[5], 32'd12);
        end
    endtask

    task automatic test_branch();
        begin_prog();
        put(0,   enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(4,   enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        put(16,  enc_i(6'h04, 5'd1, 5'd1, 16'd2));
        put(20,  enc_i(6'h08, 5'd0, 5'd5, 16'd1));
        put(28,  enc_j(26'd30));
        put(120, enc_i(6'h04, 5'd1, 5'd2, 16'd3));
        put(124, enc_i(6'h04, 5'd0, 5'd0, 16'hFFE0));
        end_prog();
        step(5);
        checks++;
        if (dut.pc.out !== 32'h1C) begin
            errors++; $display("FAIL beq_taken_pc: got %h expected %h", dut.pc.out, 32'h1C);
        end
        checks++;
        if (dut.rg.inReg[5] !== 32'd0) begin
            errors++; $display("FAIL beq_skip_r5: got %h expected %h", dut.rg.inReg[5], 32'd0);
        end
        step(1);
        checks++;
        if (dut.pc.out !== 32'd120) begin
            errors++; $display("FAIL j_pc: got %h expected %h", dut.pc.out, 32'd120);
        end
        step(1);
        checks++;
        if (dut.pc.out !== 32'd124) begin
            errors++; $display("FAIL beq_not_taken_pc: got %h expected %h", dut.pc.out, 32'd124);
        end
        step(1);
        checks++;
        if (dut.pc.out !== 32'd0) begin
            errors++; $display("FAIL beq_backward_pc: got %h expected %h", dut.pc.out, 32'd0);
        end
    endtask

    task automatic test_zero_nop();
        begin_prog();
        put(0,  enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(4,  enc_i(6'h08, 5'd0, 5'd0, 16'd9));
        put(8,  enc_i(6'h3F, 5'd1, 5'd1, 16'd9));
        put(12, enc_r(5'd1, 5'd1, 5'd1, 6'h21));
        end_prog();
        step(2);
        checks++;
        if (dut.rg.inReg[0] !== 32'd0) begin
            errors++; $display("FAIL r0_write: got %h expected %h", dut.rg.inReg[0], 32'd0);
        end
        step(1);
        checks++;
        if (dut.rg.inReg[1] !== 32'd5 || dut.pc.out !== 32'd12) begin
            errors++; $display("FAIL bad_opcode: got r1=%h pc=%h expected r1=%h pc=%h",
                               dut.rg.inReg[1], dut.pc.out, 32'd5, 32'd12);
        end
        step(1);
        checks++;
        if (dut.rg.inReg[1] !== 32'd5 || dut.pc.out !== 32'd16) begin
            errors++; $display("FAIL bad_funct: got r1=%h pc=%h expected r1=%h pc=%h",
                               dut.rg.inReg[1], dut.pc.out, 32'd5, 32'd16);
        end
    endtask

    task automatic test_mid_reset();
        int diffs;
        int nz;
        begin_prog();
        put(0,  enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(4,  enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        put(8,  enc_i(6'h2B, 5'd0, 5'd2, 16'd12));
        put(12, enc_i(6'h08, 5'd0, 5'd3, 16'd1));
        end_prog();
        step(2);
        for (int i = 0; i < DMEM_BYTES; i++) snap[i] = dut.dm.mem[i];
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if (dut.pc.out !== 32'd0) begin
            errors++; $display("FAIL midrst_pc: got %h expected %h", dut.pc.out, 32'd0);
        end
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.rg.inReg[i] !== 32'd0) nz++;
        checks++;
        if (nz !== 0) begin
            errors++; $display("FAIL midrst_regs: got %0d nonzero registers expected 0", nz);
        end
        diffs = 0;
        for (int i = 0; i < DMEM_BYTES; i++) if (dut.dm.mem[i] !== snap[i]) diffs++;
        checks++;
        if (diffs !== 0) begin
            errors++; $display("FAIL midrst_dmem: got %0d changed bytes expected 0", diffs);
        end
        step(1);
        checks++;
        if (dut.pc.out !== 32'd4 || dut.rg.inReg[1] !== 32'd5) begin
            errors++; $display("FAIL midrst_restart: got pc=%h r1=%h expected pc=%h r1=%h",
                               dut.pc.out, dut.rg.inReg[1], 32'd4, 32'd5);
        end
    endtask

    task automatic test_back_to_back();
        begin_prog();
        put(0,  enc_i(6'h08, 5'd1, 5'd1, 16'd1));
        put(4,  enc_i(6'h08, 5'd1, 5'd1, 16'd1));
        put(8,  enc_i(6'h08, 5'd1, 5'd1, 16'd1));
        put(12, enc_r(5'd1, 5'd1, 5'd2, 6'h20));
        end_prog();
        step(1);
        checks++;
        if (mon.wd !== 32'd2) begin
            errors++; $display("FAIL same_cycle_read: got wd=%h expected %h", mon.wd, 32'd2);
        end
        step(3);
        checks++;
        if (dut.rg.inReg[1] !== 32'd3 || dut.rg.inReg[2] !== 32'd6) begin
            errors++; $display("FAIL b2b: got r1=%h r2=%h expected r1=%h r2=%h",
                               dut.rg.inReg[1], dut.rg.inReg[2], 32'd3, 32'd6);
        end
    endtask

    task automatic test_alias();
        begin_prog();
        put(0, enc_i(6'h08, 5'd1, 5'd1, 16'd1));
        put(4, enc_j(26'd64));
        end_prog();
        step(2);
        checks++;
        if (dut.pc.out !== 32'd256) begin
            errors++; $display("FAIL alias_jpc: got %h expected %h", dut.pc.out, 32'd256);
        end
        step(1);
        checks++;
        if (dut.rg.inReg[1] !== 32'd2 || dut.pc.out !== 32'd260) begin
            errors++; $display("FAIL alias_fetch: got r1=%h pc=%h expected r1=%h pc=%h",
                               dut.rg.inReg[1], dut.pc.out, 32'd2, 32'd260);
        end
    endtask

    initial begin
        test_no_reset();
        test_reset();
        test_arith();
        test_alu_ops();
        test_mem();
        test_branch();
        test_zero_nop();
        test_mid_reset();
        test_back_to_back();
        test_alias();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
